avalon_st_pkt_arbiter: RTL and testbench

- Packet-atomic round-robin arbiter that merges NUM_SRC Avalon-ST source streams onto one Avalon-ST sink port, e.g. a downstream avalon_st_sink capture block.
- Once a source wins at sop, it owns the output until its eop beat transfers.
- Sits between the market-data packet generators and the shared sink/capture datapath.

---
 rtl/avalon_st_pkg.sv | 36 +++
 rtl/avalon_st_pkt_arbiter_rr_pick.sv | 39 +++
 rtl/avalon_st_pkt_arbiter.sv | 167 ++++++++++++++++
 tb/tb_avalon_st_pkt_arbiter.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/avalon_st_pkg.sv
// ============================================================================
// Module   : avalon_st_pkg
// Purpose  : Shared Avalon-ST types, arbiter state encoding and helper
//            functions for the packet arbiter and other schedulers.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package avalon_st_pkg;

   // Default beat geometry for blocks that use the fixed-width beat struct
   localparam int AVST_WIDTH   = 64;
   localparam int AVST_EMPTY_W = $clog2(AVST_WIDTH / 8);

   // One Avalon-ST beat as seen on a packet interface
   typedef struct packed {
      logic [AVST_WIDTH-1:0]   data;
      logic                    sop;
      logic                    eop;
      logic [AVST_EMPTY_W-1:0] empty;
   } avst_beat_t;

   // Arbiter ownership state
   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } arb_state_e;

   // Index width that never collapses to zero bits
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

`default_nettype wire

// File: rtl/avalon_st_pkt_arbiter_rr_pick.sv
// ============================================================================
// Module   : rr_pick
// Purpose  : Purely combinational round-robin priority picker. Returns the
//            first asserted request at or after ptr, searching upward and
//            wrapping modulo N.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick
   import avalon_st_pkg::*;
#(
   parameter int N     = 4,
   parameter int IDX_W = clog2_min1(N)
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic             gnt_valid,
   output logic [IDX_W-1:0] gnt_idx
);

   // Scan N positions starting at ptr; the first hit wins
   always_comb begin
      int k;
      gnt_valid = 1'b0;
      gnt_idx   = '0;
      k         = 0;
      for (int i = 0; i < N; i++) begin
         k = (int'(ptr) + i) % N;
         if (!gnt_valid && req[k]) begin
            gnt_valid = 1'b1;
            gnt_idx   = IDX_W'(k);
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/avalon_st_pkt_arbiter.sv
// ============================================================================
// Module   : avalon_st_pkt_arbiter
// Purpose  : Packet-atomic round-robin arbiter merging NUM_SRC Avalon-ST
//            sources onto one sink. A source that wins at sop owns the
//            output until its eop beat transfers.
// Options  : AVST_ARB_STATS_EN - adds per-source packet counters and a
//            sink-stall cycle counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module avalon_st_pkt_arbiter
   import avalon_st_pkg::*;
#(
   parameter int NUM_SRC     = 4,
   parameter int WIDTH       = 64,
   parameter int EMPTY_WIDTH = $clog2(WIDTH / 8)
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_SRC*WIDTH-1:0]       src_data,
   input  logic [NUM_SRC-1:0]             src_valid,
   input  logic [NUM_SRC-1:0]             src_sop,
   input  logic [NUM_SRC-1:0]             src_eop,
   input  logic [NUM_SRC*EMPTY_WIDTH-1:0] src_empty,
   output logic [NUM_SRC-1:0]             src_ready,
   output logic [WIDTH-1:0]               snk_data,
   output logic                           snk_valid,
   output logic                           snk_sop,
   output logic                           snk_eop,
   output logic [EMPTY_WIDTH-1:0]         snk_empty,
   input  logic                           snk_ready,
   output logic [$clog2(NUM_SRC)-1:0]     grant_idx,
   output logic                           busy,
   output logic                           err_orphan,
`ifdef AVST_ARB_STATS_EN
   output logic [NUM_SRC*32-1:0]          pkt_count,
   output logic [31:0]                    stall_cycles,
`endif
   output logic                           err_sop
);

   localparam int         IDX_W     = $clog2(NUM_SRC);
   localparam logic [0:0] ST_IDLE   = IDLE;
   localparam logic [0:0] ST_LOCKED = LOCKED;

   logic [0:0]       state;
   logic [IDX_W-1:0] rr_ptr;
   logic             mid_pkt;     // owner has already moved its first beat
   logic             pick_valid;
   logic [IDX_W-1:0] pick_idx;
   logic             own_valid;
   logic             orphan;
   logic             xfer;
   logic [IDX_W-1:0] next_ptr;

   // Candidates in IDLE are sources offering a start-of-packet beat
   rr_pick #(
      .N     (NUM_SRC),
      .IDX_W (IDX_W)
   ) u_rr_pick (
      .req       (src_valid & src_sop),
      .ptr       (rr_ptr),
      .gnt_valid (pick_valid),
      .gnt_idx   (pick_idx)
   );

   // Mux the granted source's beat onto the sink fields
   always_comb begin
      snk_data  = '0;
      snk_sop   = 1'b0;
      snk_eop   = 1'b0;
      snk_empty = '0;
      own_valid = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (grant_idx == IDX_W'(i)) begin
            snk_data  = src_data[i*WIDTH +: WIDTH];
            snk_sop   = src_sop[i];
            snk_eop   = src_eop[i];
            snk_empty = src_empty[i*EMPTY_WIDTH +: EMPTY_WIDTH];
            own_valid = src_valid[i];
         end
      end
   end

   // Handshake steering: drain orphans in IDLE, connect the owner when LOCKED
   always_comb begin
      src_ready = '0;
      snk_valid = 1'b0;
      orphan    = 1'b0;
      if (!rst) begin
         if (state == ST_IDLE) begin
            src_ready = src_valid & ~src_sop;
            orphan    = |(src_valid & ~src_sop);
         end else begin
            snk_valid = own_valid;
            for (int i = 0; i < NUM_SRC; i++) begin
               if (grant_idx == IDX_W'(i)) begin
                  src_ready[i] = snk_ready;
               end
            end
         end
      end
   end

   assign xfer     = snk_valid & snk_ready;
   assign busy     = (state == ST_LOCKED);
   assign next_ptr = (grant_idx == IDX_W'(NUM_SRC - 1)) ? '0 : grant_idx + IDX_W'(1);

   // Ownership FSM, round-robin pointer and error pulses
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         rr_ptr     <= '0;
         grant_idx  <= '0;
         mid_pkt    <= 1'b0;
         err_orphan <= 1'b0;
         err_sop    <= 1'b0;
      end else begin
         err_orphan <= orphan;
         err_sop    <= xfer & snk_sop & mid_pkt;
         case (state)
            ST_IDLE: begin
               if (pick_valid) begin
                  grant_idx <= pick_idx;
                  state     <= ST_LOCKED;
                  mid_pkt   <= 1'b0;
               end
            end
            default: begin
               if (xfer) begin
                  mid_pkt <= 1'b1;
                  if (snk_eop) begin
                     state   <= ST_IDLE;
                     rr_ptr  <= next_ptr;
                     mid_pkt <= 1'b0;
                  end
               end
            end
         endcase
      end
   end

`ifdef AVST_ARB_STATS_EN
   // Per-source completed-packet counters (wrap) and sink stall counter (saturate)
   always_ff @(posedge clk) begin
      if (rst) begin
         pkt_count    <= '0;
         stall_cycles <= '0;
      end else begin
         if (xfer && snk_eop) begin
            for (int i = 0; i < NUM_SRC; i++) begin
               if (grant_idx == IDX_W'(i)) begin
                  pkt_count[i*32 +: 32] <= pkt_count[i*32 +: 32] + 32'd1;
               end
            end
         end
         if ((state == ST_LOCKED) && own_valid && !snk_ready && (stall_cycles != 32'hFFFF_FFFF)) begin
            stall_cycles <= stall_cycles + 32'd1;
         end
      end
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_avalon_st_pkt_arbiter.sv
// ============================================================================
// Module   : tb_avalon_st_pkt_arbiter
// Purpose  : Directed self-checking bench for avalon_st_pkt_arbiter.
//            Stats checks are compiled when AVST_ARB_STATS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_avalon_st_pkt_arbiter;

   localparam int NS = 4;
   localparam int W  = 64;
   localparam int EW = 3;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [NS*W-1:0] src_data  = '0;
   logic [NS-1:0]   src_valid = '0;
   logic [NS-1:0]   src_sop   = '0;
   logic [NS-1:0]   src_eop   = '0;
   logic [NS*EW-1:0] src_empty = '0;
   logic [NS-1:0]   src_ready;
   logic [W-1:0]    snk_data;
   logic            snk_valid, snk_sop, snk_eop;
   logic [EW-1:0]   snk_empty;
   logic            snk_ready = 1'b1;
   logic [1:0]      grant_idx;
   logic            busy, err_orphan, err_sop;
`ifdef AVST_ARB_STATS_EN
   logic [NS*32-1:0] pkt_count;
   logic [31:0]      stall_cycles;
`endif

   avalon_st_pkt_arbiter #(.NUM_SRC(NS), .WIDTH(W), .EMPTY_WIDTH(EW)) dut (
      .clk(clk), .rst(rst),
      .src_data(src_data), .src_valid(src_valid), .src_sop(src_sop),
      .src_eop(src_eop), .src_empty(src_empty), .src_ready(src_ready),
      .snk_data(snk_data), .snk_valid(snk_valid), .snk_sop(snk_sop),
      .snk_eop(snk_eop), .snk_empty(snk_empty), .snk_ready(snk_ready),
      .grant_idx(grant_idx), .busy(busy), .err_orphan(err_orphan),
`ifdef AVST_ARB_STATS_EN
      .pkt_count(pkt_count), .stall_cycles(stall_cycles),
`endif
      .err_sop(err_sop)
   );

   always #5 clk = ~clk;

   // Per-source beat queues and sink transfer log
   logic [63:0]   q_data  [NS][32];
   logic          q_sop   [NS][32];
   logic          q_eop   [NS][32];
   logic [EW-1:0] q_empty [NS][32];
   int            q_len [NS];
   int            q_pos [NS];
   logic [63:0]   log_data [$];
   logic          log_eop  [$];
   logic [EW-1:0] log_empty[$];

   int n_total = 0;
   int n_bad   = 0;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic load_raw(input int s, input logic [63:0] d, input logic sop, input logic eop, input logic [EW-1:0] e);
      q_data[s][q_len[s]]  = d;
      q_sop[s][q_len[s]]   = sop;
      q_eop[s][q_len[s]]   = eop;
      q_empty[s][q_len[s]] = e;
      q_len[s]++;
   endtask

   task automatic load(input int s, input int n, input logic [63:0] base, input logic [EW-1:0] e);
      for (int b = 0; b < n; b++)
         load_raw(s, base + 64'(b), (b == 0), (b == n - 1), (b == n - 1) ? e : '0);
   endtask

   task automatic drive();
      for (int s = 0; s < NS; s++) begin
         if (q_pos[s] < q_len[s]) begin
            src_valid[s]          = 1'b1;
            src_data[s*W +: W]    = q_data[s][q_pos[s]];
            src_sop[s]            = q_sop[s][q_pos[s]];
            src_eop[s]            = q_eop[s][q_pos[s]];
            src_empty[s*EW +: EW] = q_empty[s][q_pos[s]];
         end else begin
            src_valid[s]          = 1'b0;
            src_data[s*W +: W]    = '0;
            src_sop[s]            = 1'b0;
            src_eop[s]            = 1'b0;
            src_empty[s*EW +: EW] = '0;
         end
      end
   endtask

   // Sample handshakes before the edge, advance sources after it
   task automatic tick();
      logic [NS-1:0] fire;
      fire = src_valid & src_ready;
      if (snk_valid && snk_ready) begin
         log_data.push_back(snk_data);
         log_eop.push_back(snk_eop);
         log_empty.push_back(snk_empty);
      end
      @(posedge clk);
      #1;
      for (int s = 0; s < NS; s++) if (fire[s]) q_pos[s]++;
      drive();
      #1;
   endtask

   task automatic clear_all();
      for (int s = 0; s < NS; s++) begin
         q_len[s] = 0;
         q_pos[s] = 0;
      end
      log_data.delete();
      log_eop.delete();
      log_empty.delete();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      snk_ready = 1'b1;
      clear_all();
      drive();
      tick();
      rst = 1'b0;
      #1;
   endtask

   initial begin
      logic [5:0] exp_v;
      int nvalid;

      // ---------------- reset state ----------------
      clear_all();
      for (int s = 0; s < NS; s++) load(s, 1, 64'hF0 + 64'(s), '0);
      drive();
      @(posedge clk);
      #2;
      check_val("rst_src_ready", src_ready, 4'b0000);
      check_val("rst_snk_valid", snk_valid, 1'b0);
      tick();
      check_val("rst_busy", busy, 1'b0);
      check_val("rst_grant", grant_idx, 2'd0);
      check_val("rst_err_orphan", err_orphan, 1'b0);
      check_val("rst_err_sop", err_sop, 1'b0);

      // ---------------- single 4-beat packet from source 0 ----------------
      do_reset();
      load(0, 4, 64'h100, 3'd3);
      drive();
      #1;
      check_val("t1_cand_ready", src_ready, 4'b0000);
      exp_v = 6'b011110;
      for (int i = 0; i < 6; i++) begin
         check_val($sformatf("t1_valid_c%0d", i), snk_valid, exp_v[i]);
         tick();
      end
      check_val("t1_log_size", log_data.size(), 4);
      for (int j = 0; j < 4; j++)
         if (j < log_data.size()) check_val($sformatf("t1_data%0d", j), log_data[j], 64'h100 + 64'(j));
      if (log_data.size() == 4) begin
         check_val("t1_eop_last", log_eop[3], 1'b1);
         check_val("t1_eop_first", log_eop[0], 1'b0);
         check_val("t1_empty_last", log_empty[3], 3'd3);
      end

      // rr_ptr is now 1: source 1 beats source 0
      clear_all();
      load(0, 1, 64'h200, '0);
      load(1, 1, 64'h210, '0);
      drive();
      #1;
      tick();
      check_val("t1_ptr_grant", grant_idx, 2'd1);
      check_val("t1_ptr_data", snk_data, 64'h210);
      repeat (4) tick();
      check_val("t1_ptr_log_n", log_data.size(), 2);
      if (log_data.size() == 2) begin
         check_val("t1_ptr_first", log_data[0], 64'h210);
         check_val("t1_ptr_second", log_data[1], 64'h200);
      end

      // ---------------- four contending 2-beat packets ----------------
      do_reset();
      for (int s = 0; s < NS; s++) load(s, 2, 64'h300 + 64'(s * 16), '0);
      drive();
      #1;
      nvalid = 0;
      for (int i = 0; i < 12; i++) begin
         if (snk_valid) nvalid++;
         tick();
      end
      check_val("t2_valid_cycles", nvalid, 8);
      check_val("t2_idle_after", busy, 1'b0);
      check_val("t2_src3_drained", q_pos[3], 2);
      check_val("t2_log_n", log_data.size(), 8);
      for (int j = 0; j < 8; j++)
         if (j < log_data.size())
            check_val($sformatf("t2_order%0d", j), log_data[j], 64'h300 + 64'((j / 2) * 16 + (j % 2)));

      // ---------------- backpressure mid-packet with a competing sop ----------------
      do_reset();
      load(2, 3, 64'h400, 3'd1);
      drive();
      #1;
      tick();
      check_val("t3_grant2", grant_idx, 2'd2);
      tick();
      load(1, 1, 64'h500, 3'd2);
      drive();
      snk_ready = 1'b0;
      #1;
      check_val("t3_hold_ready", src_ready, 4'b0000);
      check_val("t3_hold_data", snk_data, 64'h401);
      tick();
      check_val("t3_hold2_data", snk_data, 64'h401);
      check_val("t3_hold2_grant", grant_idx, 2'd2);
      check_val("t3_hold2_busy", busy, 1'b1);
      tick();
      snk_ready = 1'b1;
      #1;
      tick();
      tick();
      check_val("t3_release_busy", busy, 1'b0);
      tick();
      check_val("t3_next_grant", grant_idx, 2'd1);
      check_val("t3_next_data", snk_data, 64'h500);
      tick();
      check_val("t3_log_n", log_data.size(), 4);
      if (log_data.size() == 4) begin
         check_val("t3_b0", log_data[0], 64'h400);
         check_val("t3_b1", log_data[1], 64'h401);
         check_val("t3_b2", log_data[2], 64'h402);
         check_val("t3_b3", log_data[3], 64'h500);
      end

      // ---------------- orphan beat in IDLE ----------------
      do_reset();
      load_raw(3, 64'h600, 1'b0, 1'b0, '0);
      drive();
      #1;
      check_val("t4_orphan_ready", src_ready, 4'b1000);
      check_val("t4_orphan_snk_valid", snk_valid, 1'b0);
      check_val("t4_orphan_pre", err_orphan, 1'b0);
      tick();
      check_val("t4_orphan_pulse", err_orphan, 1'b1);
      check_val("t4_orphan_busy", busy, 1'b0);
      check_val("t4_orphan_consumed", src_valid[3], 1'b0);
      tick();
      check_val("t4_orphan_clear", err_orphan, 1'b0);
      check_val("t4_orphan_log", log_data.size(), 0);

      // ---------------- sop repeated mid-packet ----------------
      do_reset();
      load_raw(0, 64'h900, 1'b1, 1'b0, '0);
      load_raw(0, 64'h901, 1'b1, 1'b0, '0);
      load_raw(0, 64'h902, 1'b0, 1'b1, 3'd5);
      drive();
      #1;
      tick();
      check_val("t5_err_sop_first", err_sop, 1'b0);
      tick();
      check_val("t5_sop_pass", snk_sop, 1'b1);
      check_val("t5_sop_data", snk_data, 64'h901);
      tick();
      check_val("t5_err_sop_pulse", err_sop, 1'b1);
      check_val("t5_eop_empty", snk_empty, 3'd5);
      tick();
      check_val("t5_err_sop_clear", err_sop, 1'b0);
      check_val("t5_idle", busy, 1'b0);

      // ---------------- reset in the middle of a packet ----------------
      do_reset();
      load(2, 3, 64'h700, '0);
      drive();
      #1;
      tick();
      tick();
      rst = 1'b1;
      #1;
      check_val("t6_rst_valid", snk_valid, 1'b0);
      check_val("t6_rst_ready", src_ready, 4'b0000);
      tick();
      rst = 1'b0;
      q_len[2] = q_pos[2];
      load(0, 1, 64'h800, '0);
      drive();
      #1;
      check_val("t6_busy", busy, 1'b0);
      check_val("t6_grant", grant_idx, 2'd0);
      check_val("t6_snk_valid", snk_valid, 1'b0);
      tick();
      check_val("t6_new_busy", busy, 1'b1);
      check_val("t6_new_data", snk_data, 64'h800);
      tick();
      check_val("t6_log_n", log_data.size(), 2);
      if (log_data.size() == 2) check_val("t6_log_last", log_data[1], 64'h800);

`ifdef AVST_ARB_STATS_EN
      // ---------------- statistics ----------------
      do_reset();
      for (int p = 0; p < 5; p++) load(1, 1, 64'hA10 + 64'(p), '0);
      for (int p = 0; p < 2; p++) load(3, 1, 64'hA30 + 64'(p), '0);
      drive();
      #1;
      repeat (16) tick();
      check_val("st_pkt0", pkt_count[0 +: 32], 32'd0);
      check_val("st_pkt1", pkt_count[32 +: 32], 32'd5);
      check_val("st_pkt2", pkt_count[64 +: 32], 32'd0);
      check_val("st_pkt3", pkt_count[96 +: 32], 32'd2);
      load(0, 2, 64'hB00, '0);
      drive();
      #1;
      tick();
      snk_ready = 1'b0;
      #1;
      repeat (7) tick();
      check_val("st_stall", stall_cycles, 32'd7);
      snk_ready = 1'b1;
      #1;
      repeat (3) tick();
      check_val("st_pkt0_after", pkt_count[0 +: 32], 32'd1);
`endif

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
